// File: rtl/pattern_stream_gen_pkg.sv
// Shared definitions for the pattern stream generator: mode encodings and
// default seed / LFSR tap mask.
package stream_gen_pkg;

   typedef enum logic [1:0] {
      MODE_UP   = 2'd0,
      MODE_DOWN = 2'd1,
      MODE_LFSR = 2'd2,
      MODE_WALK = 2'd3
   } mode_e;

   localparam logic [31:0] DEFAULT_SEED = 32'hFAFBFCFD;
   localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

endpackage

// File: rtl/pattern_stream_gen_if.sv
// Valid/ready stream carrying the generated pattern words.
interface pattern_stream_gen_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pattern_stream_gen_step.sv
// Combinational next-pattern function: count up/down, Galois LFSR, walking one.
module pattern_step
   import stream_gen_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
   input  logic [WIDTH-1:0] cur,
   input  mode_e            mode,
   output logic [WIDTH-1:0] nxt
);

   logic [WIDTH-1:0] lfsr_val;

   always_comb begin
      lfsr_val = (cur >> 1) ^ (cur[0] ? POLY : '0);
      nxt      = cur;
      case (mode)
         MODE_UP:   nxt = cur + WIDTH'(1);
         MODE_DOWN: nxt = cur - WIDTH'(1);
         // An all-zero LFSR state would lock up, so it is forced back to 1.
         MODE_LFSR: nxt = (lfsr_val == '0) ? WIDTH'(1) : lfsr_val;
         MODE_WALK: nxt = (cur == '0) ? WIDTH'(1) : {cur[WIDTH-2:0], cur[WIDTH-1]};
      endcase
   end

endmodule

// File: rtl/pattern_stream_gen.sv
// Rate-timed pattern source: offers one word every period+1 enabled cycles,
// counts accepted words and words dropped because the previous one was still pending.
module pattern_stream_gen
   import stream_gen_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               PERIOD_W = 8,
   parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
   parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEFAULT_POLY)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   input  logic [1:0]          mode,
   input  logic                reload,
   pattern_stream_gen_if.master stream,
   output logic [31:0]         words,
   output logic [15:0]         missed,
   output logic                ovf
);

   logic [PERIOD_W-1:0] timer_reg;
   logic                valid_reg;
   logic [WIDTH-1:0]    data_reg;
   logic [31:0]         words_reg;
   logic [15:0]         missed_reg;
   logic                ovf_reg;

   logic                due;
   logic                hs;
   logic [WIDTH-1:0]    step_nxt;
   logic [WIDTH-1:0]    reload_val;

   // The >= compare lets a shrinking period take effect without a wrap.
   assign due = en && (timer_reg >= period);
   assign hs  = valid_reg && stream.ready;

   pattern_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .cur  (data_reg),
      .mode (mode_e'(mode)),
      .nxt  (step_nxt)
   );

   always_comb begin
      reload_val = SEED;
      if (mode_e'(mode) == MODE_WALK || (mode_e'(mode) == MODE_LFSR && SEED == '0))
         reload_val = WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_reg  <= '0;
         valid_reg  <= 1'b0;
         data_reg   <= SEED;
         words_reg  <= '0;
         missed_reg <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (en)
            timer_reg <= due ? '0 : timer_reg + PERIOD_W'(1);

         if (due)
            valid_reg <= 1'b1;
         else if (hs)
            valid_reg <= 1'b0;

         if (reload)
            data_reg <= reload_val;
         else if (hs)
            data_reg <= step_nxt;

         if (hs)
            words_reg <= words_reg + 32'd1;

         if (due && valid_reg && !hs) begin
            ovf_reg <= 1'b1;
            if (missed_reg != 16'hFFFF)
               missed_reg <= missed_reg + 16'd1;
         end
      end
   end

   assign stream.data  = data_reg;
   assign stream.valid = valid_reg;
   assign words        = words_reg;
   assign missed       = missed_reg;
   assign ovf          = ovf_reg;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model of the generator.
module tb_pattern_stream_gen;

   localparam logic [31:0] SEED = 32'hFAFBFCFD;
   localparam logic [31:0] POLY = 32'h80200003;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  period;
   logic [1:0]  mode;
   logic        reload;
   logic [31:0] words, words8;
   logic [15:0] missed, missed8;
   logic        ovf, ovf8;

   pattern_stream_gen_if #(.WIDTH(32)) s_if ();
   pattern_stream_gen_if #(.WIDTH(8))  s8_if ();
   assign s8_if.ready = s_if.ready;

   pattern_stream_gen dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .period (period),
      .mode   (mode),
      .reload (reload),
      .stream (s_if),
      .words  (words),
      .missed (missed),
      .ovf    (ovf)
   );

   pattern_stream_gen #(.WIDTH(8), .SEED(8'hFD), .POLY(8'hB8)) dut8 (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .period (period),
      .mode   (mode),
      .reload (reload),
      .stream (s8_if),
      .words  (words8),
      .missed (missed8),
      .ovf    (ovf8)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Reference model state
   logic [7:0]  m_timer;
   bit          m_valid;
   logic [31:0] m_data;
   logic [31:0] m_words;
   int          m_missed;
   bit          m_ovf;

   function automatic logic [31:0] ref_next(input logic [31:0] cur, input int m);
      logic [31:0] n;
      case (m)
         0: n = cur + 1;
         1: n = cur - 1;
         2: begin
            n = cur >> 1;
            if (cur[0]) n = n ^ POLY;
            if (n == 0) n = 1;
         end
         default: n = (cur == 0) ? 32'd1 : ((cur << 1) | (cur >> 31));
      endcase
      return n;
   endfunction

   task automatic model_reset();
      m_timer = 0; m_valid = 0; m_data = SEED; m_words = 0; m_missed = 0; m_ovf = 0;
   endtask

   task automatic model_edge();
      bit due, hs;
      due = en && (m_timer >= period);
      hs  = m_valid && s_if.ready;
      if (en) m_timer = due ? 8'd0 : m_timer + 8'd1;
      if (hs) m_words = m_words + 1;
      if (due && m_valid && !hs) begin
         m_ovf = 1;
         if (m_missed < 65535) m_missed++;
      end
      if (reload)  m_data = (mode == 2'd3) ? 32'd1 : SEED;
      else if (hs) m_data = ref_next(m_data, int'(mode));
      if (due) m_valid = 1;
      else if (hs) m_valid = 0;
   endtask

   task automatic check_all(input string ph);
      chk({ph, "_valid"},  {31'd0, s_if.valid}, {31'd0, m_valid});
      chk({ph, "_data"},   s_if.data, m_data);
      chk({ph, "_words"},  words, m_words);
      chk({ph, "_missed"}, {16'd0, missed}, m_missed[31:0]);
      chk({ph, "_ovf"},    {31'd0, ovf}, {31'd0, m_ovf});
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check_all(ph);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] sw;
      logic [7:0]  w8;
      int          rdy_pct;

      rst = 1'b1; en = 1'b0; period = 8'd7; mode = 2'd0; reload = 1'b0;
      s_if.ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check_all("reset");

      // Rate timer with period 7: first word after 8 enabled edges
      en = 1'b1; s_if.ready = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         step("p7");
         if (i == 8)  begin chk("p7_first_valid", {31'd0, s_if.valid}, 32'd1); chk("p7_first_data", s_if.data, 32'hFAFBFCFD); end
         if (i == 16) begin chk("p7_second_valid", {31'd0, s_if.valid}, 32'd1); chk("p7_second_data", s_if.data, 32'hFAFBFCFE); end
         if (i == 17) chk("p7_words", words, 32'd2);
      end

      // Period 0 with ready held: one word per cycle
      period = 8'd0;
      do_reset();
      repeat (100) step("p0");
      chk("p0_words", words, 32'd99);
      chk("p0_missed", {16'd0, missed}, 32'd0);
      chk("p0_data", s_if.data, SEED + 32'd99);

      // Back-pressure: period 3, ready low for 20 cycles
      period = 8'd3; s_if.ready = 1'b0;
      do_reset();
      repeat (20) step("bp");
      chk("bp_missed", {16'd0, missed}, 32'd4);
      chk("bp_ovf", {31'd0, ovf}, 32'd1);
      chk("bp_data", s_if.data, SEED);
      s_if.ready = 1'b1;
      step("bp");
      chk("bp_accept", words, 32'd1);

      // LFSR mode against an independent software LFSR
      mode = 2'd2; period = 8'd0; reload = 1'b1;
      step("lfsr");
      reload = 1'b0;
      sw = SEED;
      chk("lfsr_seed", s_if.data, sw);
      for (int i = 0; i < 1000; i++) begin
         step("lfsr");
         sw = (sw >> 1) ^ (sw[0] ? POLY : 32'd0);
         if (sw == 0) sw = 1;
         chk("lfsr_seq", s_if.data, sw);
         chk("lfsr_nonzero", {31'd0, s_if.data != 0}, 32'd1);
      end

      // Walking one on the 8-bit instance
      mode = 2'd3; reload = 1'b1;
      step("walk");
      reload = 1'b0;
      w8 = 8'h01;
      chk("walk8_start", {24'd0, s8_if.data}, {24'd0, w8});
      for (int i = 0; i < 9; i++) begin
         step("walk");
         w8 = {w8[6:0], w8[7]};
         chk("walk8", {24'd0, s8_if.data}, {24'd0, w8});
      end

      // Randomized traffic
      rdy_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) rdy_pct = $urandom_range(10, 95);
         en         = ($urandom_range(0, 3) != 0);
         s_if.ready = ($urandom_range(0, 99) < rdy_pct);
         reload     = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) period = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
         step("rand");
      end
      reload = 1'b0;

      // Asynchronous reset while a word is pending and the timer is mid-count
      en = 1'b1; period = 8'd5; s_if.ready = 1'b0; mode = 2'd0;
      for (int k = 0; k < 50 && !m_valid; k++) step("arm");
      chk("arm_valid", {31'd0, s_if.valid}, 32'd1);
      repeat (2) step("arm");
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      @(posedge clk); #1;
      check_all("rst_hold");
      @(negedge clk); rst = 1'b0;
      s_if.ready = 1'b1;
      repeat (10) step("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pattern_stream_gen.md
PATTERN_STREAM_GEN -- requirements
Module: pattern_stream_gen

Interface
REQ-001 Parameter WIDTH, default 32: width of the generated data word.
REQ-002 Parameter PERIOD_W, default 8: width of the period input.
REQ-003 Parameter SEED, default 32'hFAFBFCFD truncated to WIDTH: reset or reload value of the pattern register.
REQ-004 Parameter POLY, default 32'h80200003 truncated to WIDTH: Galois LFSR tap mask.
REQ-005 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port en, input, 1: enables the rate timer.
REQ-008 Port period, input, PERIOD_W: a word becomes due every period+1 enabled cycles.
REQ-009 Port mode, input, 2: pattern select (0 count up, 1 count down, 2 LFSR, 3 walking one).
REQ-010 Port reload, input, 1: single-cycle pulse that reloads the pattern to its mode start value.
REQ-011 Port data, output, WIDTH: current word.
REQ-012 Port valid, output, 1: data is offered.
REQ-013 Port ready, input, 1: consumer accepts data when valid && ready.
REQ-014 Port words, output, 32: count of accepted words, wrapping.
REQ-015 Port missed, output, 16: count of due words dropped, saturating at 16'hFFFF.
REQ-016 Port ovf, output, 1: sticky flag, set by the first missed word.

Function
REQ-017 The timer SHALL increment on each cycle with en=1; when timer >= period it SHALL load 0 and raise "due" for that cycle.
REQ-018 When en=0 the timer SHALL hold its value; a pending valid word SHALL remain offered.
REQ-019 If due and valid=0, valid SHALL be 1 from the next edge; data SHALL be unchanged.
REQ-020 If due and valid=1 with no handshake in that cycle, missed SHALL increment (saturating), ovf SHALL set, and data SHALL be unchanged.
REQ-021 If due and a handshake occur in the same cycle, valid SHALL stay 1 and data SHALL advance once, with no miss counted.
REQ-022 On a handshake without due, valid SHALL go to 0, data SHALL advance once, and words SHALL increment.
REQ-023 Data SHALL be stable while valid && !ready.
REQ-024 Advance rules (mode sampled at the advance edge):
  - mode 0: +1 mod 2^WIDTH.
  - mode 1: -1 mod 2^WIDTH.
  - mode 2: Galois shift right, XOR POLY if the LSB is 1; an all-zero result SHALL be replaced by 1.
  - mode 3: rotate left by 1; a zero value SHALL be replaced by 1.
REQ-025 reload SHALL set data to SEED for modes 0-2 and to 1 for mode 3.
  - A seed of zero in mode 2 SHALL load 1.
  - reload SHALL take priority over an advance in the same cycle.
  - reload SHALL NOT change valid, timer or the counters.
REQ-026 With period=0 and ready held at 1, one word SHALL be accepted every enabled cycle after the first valid.
REQ-027 A period change SHALL take effect immediately through the >= compare, with no extra wait.

Reset
REQ-028 rst=1 SHALL asynchronously set: timer=0, valid=0, data=SEED, words=0, missed=0, ovf=0.
REQ-029 rst asserted mid-handshake SHALL discard the offered word, with no count update.
REQ-030 Outputs SHALL be held at their reset values until the first clk edge after rst falls.

Structure
REQ-031 Package stream_gen_pkg SHALL hold the mode encodings (MODE_UP, MODE_DOWN, MODE_LFSR, MODE_WALK), the default SEED and the default POLY.
REQ-032 The next-value computation SHALL be a combinational sub-module pattern_step (inputs cur and mode, output nxt; parameters WIDTH and POLY).

Verification
REQ-033 period=7, mode 0, ready=1, en held from reset release -> valid rises after 8 enabled edges with data=FAFBFCFD, then FAFBFCFE is accepted 8 cycles later.
REQ-034 period=0, ready=1, 100 cycles -> words=99, missed=0, data increments by 1 every cycle.
REQ-035 period=3, ready=0 for 20 cycles -> data frozen, missed=4 (one per due edge after the first), ovf=1; then ready=1 -> one word accepted.
REQ-036 Mode 2, WIDTH=32, reload -> sequence matches a software Galois LFSR with POLY for 1000 words, never zero.
REQ-037 Mode 3, WIDTH=8, reload -> data 01,02,04,...,80,01 across 9 handshakes.
REQ-038 rst pulsed while valid=1 and the timer is mid-count -> valid=0, data=SEED, counters=0 immediately, without waiting for a clk edge.
